// File: rtl/sequential_16bit_en_pkg.sv
// Shared sizing defaults and pad-bit assignments for the 16-bit enabled counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sequential_16bit_en_pkg;

    // Default counter width, pad bus width and pad index of counter bit 0.
    localparam int DEFAULT_WIDTH    = 16;
    localparam int DEFAULT_IO_WIDTH = 28;
    localparam int DEFAULT_OUT_LSB  = 12;

    // Control bits taken from the input pad bus.
    localparam int CLR_BIT = 0;
    localparam int EN_BIT  = 1;

endpackage : sequential_16bit_en_pkg

// File: rtl/sequential_16bit_en_counter.sv
// Free-running modulo-2^WIDTH counter with synchronous clear (priority) and enable.
// Latency: 1 clock from clr/en sampling to q; async reset clears q immediately.
// Backpressure: none; wraps silently from all-ones to zero.
module counter_en #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next-state: clear wins over enable, otherwise increment or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register; reset is asynchronous so the pads drop to zero without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q = count_q;

endmodule : counter_en

// File: rtl/sequential_16bit_en.sv
// Pad wrapper: maps a clear/enable counter onto a pad bus with fixed output enables.
// Latency: 1 clock from io_in[1:0] sampling to io_out; no combinational io_in->io_out path.
// Backpressure: none; io_oeb and non-counter io_out bits are constants.
module sequential_16bit_en
    import sequential_16bit_en_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int IO_WIDTH = DEFAULT_IO_WIDTH,
    parameter int OUT_LSB  = DEFAULT_OUT_LSB   // OUT_LSB + WIDTH must not exceed IO_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IO_WIDTH-1:0] io_in,
    output logic [IO_WIDTH-1:0] io_out,
    output logic [IO_WIDTH-1:0] io_oeb
);

    logic [WIDTH-1:0] count;

    // Only the clear and enable pads matter; the rest are deliberately dropped.
    logic unused_io_in;
    assign unused_io_in = ^io_in[IO_WIDTH-1:EN_BIT+1];

    counter_en #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk (clk),
        .rst (rst),
        .clr (io_in[CLR_BIT]),
        .en  (io_in[EN_BIT]),
        .q   (count)
    );

    // Counter drives its pad slice; every other pad is a constant low input-only pad.
    always_comb begin
        io_out                      = '0;
        io_out[OUT_LSB +: WIDTH]    = count;
        io_oeb                      = '1;
        io_oeb[OUT_LSB +: WIDTH]    = '0;
    end

endmodule : sequential_16bit_en

// File: tb/tb_sequential_16bit_en.sv
module tb_sequential_16bit_en;

    localparam logic [27:0] OEB_EXP = 28'h0000FFF;

    logic        clk;
    logic        rst;
    logic [27:0] io_in;
    logic [27:0] io_out;
    logic [27:0] io_oeb;

    int checks   = 0;
    int failures = 0;

    // Reference count: plain integer arithmetic on the sampled pad controls.
    int model_cnt = 0;

    sequential_16bit_en dut (
        .clk    (clk),
        .rst    (rst),
        .io_in  (io_in),
        .io_out (io_out),
        .io_oeb (io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst)
            model_cnt = 0;
        else if (io_in[0] === 1'b1)
            model_cnt = 0;
        else if (io_in[1] === 1'b1)
            model_cnt = (model_cnt + 1) % 65536;
    end

    task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%07h expected 0x%07h at %0t", name, act, exp, $time);
        end
    endtask

    // Every falling edge: outputs must equal the model's count on the counter pads.
    always @(negedge clk) begin
        chk("model_out", io_out, 28'(model_cnt) << 12);
        chk("model_oeb", io_oeb, OEB_EXP);
    end

    // One clock: present v, let the next rising edge sample it, return at the falling edge.
    task automatic cyc(input logic [27:0] v);
        io_in = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected < 5000000", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        logic [27:0] xv;
        rst   = 1'b1;
        io_in = 28'h0;
        #3;
        chk("reset_out", io_out, 28'h0000000);
        chk("reset_oeb", io_oeb, OEB_EXP);

        // Enable asserted while in reset must not count.
        io_in = 28'h2;
        @(negedge clk);
        @(negedge clk);
        chk("reset_holds", io_out, 28'h0000000);
        rst = 1'b0;

        // Clear for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            cyc(28'h3);
            chk("clear_out", io_out, 28'h0000000);
            chk("clear_oeb", io_oeb, 28'h0000FFF);
        end

        // Count 1..100.
        for (int i = 1; i <= 100; i++) begin
            cyc(28'h2);
            chk("count_step", io_out, 28'(i) << 12);
            chk("count_lowpads", {16'h0, io_out[11:0]}, 28'h0);
        end
        chk("count_100", io_out, 28'h0064000);

        // Hold at 5.
        cyc(28'h1);
        for (int i = 0; i < 5; i++) cyc(28'h2);
        chk("hold_start", io_out, 28'h0005000);
        for (int i = 0; i < 10; i++) begin
            cyc(28'h0);
            chk("hold", io_out, 28'h0005000);
        end

        // Glitches between edges are ignored.
        io_in = 28'h0;
        #1 io_in = 28'h3;
        #1 io_in = 28'h2;
        #1 io_in = 28'h0;
        @(posedge clk);
        @(negedge clk);
        chk("glitch_hold", io_out, 28'h0005000);

        // Unknowns on ignored pads do not disturb counting.
        xv = 'x;
        xv[1:0] = 2'b10;
        cyc(xv);
        chk("x_upper_pads", io_out, 28'h0006000);
        chk("x_upper_oeb", io_oeb, 28'h0000FFF);

        // Clear priority at 0x1234.
        cyc(28'h1);
        for (int i = 0; i < 32'h1234; i++) cyc(28'h2);
        chk("pre_priority", io_out, 28'h1234000);
        cyc(28'h3);
        chk("priority_clear", io_out, 28'h0000000);

        // Async reset at 0x42.
        for (int i = 0; i < 32'h42; i++) cyc(28'h2);
        chk("pre_async", io_out, 28'h0042000);
        io_in = 28'h0;
        #1 rst = 1'b1;
        #1;
        chk("async_immediate", io_out, 28'h0000000);
        @(posedge clk);
        @(negedge clk);
        chk("async_held", io_out, 28'h0000000);
        rst = 1'b0;
        cyc(28'h2);
        chk("async_restart1", io_out, 28'h0001000);
        cyc(28'h2);
        chk("async_restart2", io_out, 28'h0002000);

        // Wrap through 0xFFFF.
        cyc(28'h1);
        for (int i = 1; i <= 65537; i++) begin
            cyc(28'h2);
            if (i == 65535) chk("wrap_ffff", io_out, 28'hFFFF000);
            if (i == 65536) chk("wrap_0000", io_out, 28'h0000000);
            if (i == 65537) chk("wrap_0001", io_out, 28'h0001000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sequential_16bit_en
